// File: rtl/fpu_rs.sv
// Reservation station in front of the fpu execution unit: buffers issued ops, snoops the CDB,
// dispatches ready entries and broadcasts results. Optional macro: FPU_RS_EAGER_FREE_EN.
module fpu_rs #(
  parameter int unsigned RS_DEPTH    = 4,
  parameter int unsigned EU_CTL_LEN  = 4,
  parameter int unsigned EXCEPT_LEN  = 2,
  parameter int unsigned ROB_IDX_LEN = 5,
  parameter int unsigned XLEN        = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic [EU_CTL_LEN-1:0]        issue_eu_ctl_i,
  input  logic                         issue_rs1_ready_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_rs1_idx_i,
  input  logic [XLEN-1:0]              issue_rs1_value_i,
  input  logic                         issue_rs2_ready_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_rs2_idx_i,
  input  logic [XLEN-1:0]              issue_rs2_value_i,
  input  logic [ROB_IDX_LEN-1:0]       issue_dest_idx_i,
  output logic                         eu_valid_o,
  input  logic                         eu_ready_i,
  output logic [EU_CTL_LEN-1:0]        eu_ctl_o,
  output logic [XLEN-1:0]              eu_rs1_o,
  output logic [XLEN-1:0]              eu_rs2_o,
  output logic [$clog2(RS_DEPTH)-1:0]  eu_entry_idx_o,
  input  logic                         eu_valid_i,
  output logic                         eu_ready_o,
  input  logic [$clog2(RS_DEPTH)-1:0]  eu_entry_idx_i,
  input  logic [XLEN-1:0]              eu_result_i,
  input  logic                         eu_except_raised_i,
  input  logic [EXCEPT_LEN-1:0]        eu_except_code_i,
  input  logic                         cdb_valid_i,
  input  logic [ROB_IDX_LEN-1:0]       cdb_idx_i,
  input  logic [XLEN-1:0]              cdb_data_i,
  output logic                         cdb_valid_o,
  input  logic                         cdb_ready_i,
  output logic [ROB_IDX_LEN-1:0]       cdb_idx_o,
  output logic [XLEN-1:0]              cdb_data_o,
  output logic                         cdb_except_raised_o,
  output logic [EXCEPT_LEN-1:0]        cdb_except_code_o
);

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  typedef enum logic [2:0] {EMPTY, WAIT_OP, READY, EXEC, DONE} entry_state_t;

  entry_state_t           state_q   [RS_DEPTH];
  entry_state_t           state_d   [RS_DEPTH];
  logic [EU_CTL_LEN-1:0]  ctl_q     [RS_DEPTH];
  logic                   rs1_rdy_q [RS_DEPTH];
  logic                   rs2_rdy_q [RS_DEPTH];
  logic [ROB_IDX_LEN-1:0] rs1_idx_q [RS_DEPTH];
  logic [ROB_IDX_LEN-1:0] rs2_idx_q [RS_DEPTH];
  logic [XLEN-1:0]        rs1_val_q [RS_DEPTH];
  logic [XLEN-1:0]        rs2_val_q [RS_DEPTH];
  logic [ROB_IDX_LEN-1:0] dest_q    [RS_DEPTH];
  logic [XLEN-1:0]        res_q     [RS_DEPTH];
  logic                   exr_q     [RS_DEPTH];
  logic [EXCEPT_LEN-1:0]  exc_q     [RS_DEPTH];

  logic issue_we [RS_DEPTH];
  logic cap1     [RS_DEPTH];
  logic cap2     [RS_DEPTH];
  logic res_we   [RS_DEPTH];

  logic             any_empty, any_ready, any_done;
  logic [IDX_W-1:0] free_idx, rdy_idx, done_idx, alloc_idx;
  logic             issue_fire, eu_fire, cdb_fire;
  logic             iss_rs1_avail, iss_rs2_avail;
  logic [XLEN-1:0]  iss_rs1_val, iss_rs2_val;

  // Downward scan so the lowest matching index wins.
  always_comb begin
    any_empty = 1'b0;
    any_ready = 1'b0;
    any_done  = 1'b0;
    free_idx  = '0;
    rdy_idx   = '0;
    done_idx  = '0;
    for (int unsigned i = RS_DEPTH; i > 0; i--) begin
      if (state_q[i-1] == EMPTY) begin
        any_empty = 1'b1;
        free_idx  = IDX_W'(i-1);
      end
      if (state_q[i-1] == READY) begin
        any_ready = 1'b1;
        rdy_idx   = IDX_W'(i-1);
      end
      if (state_q[i-1] == DONE) begin
        any_done = 1'b1;
        done_idx = IDX_W'(i-1);
      end
    end
  end

  assign eu_valid_o  = any_ready;
  assign cdb_valid_o = any_done;
  assign eu_ready_o  = !rst_i;
  assign eu_fire     = eu_valid_o && eu_ready_i;
  assign cdb_fire    = cdb_valid_o && cdb_ready_i;

`ifdef FPU_RS_EAGER_FREE_EN
  // A full station may refill the DONE entry that the CDB is draining this cycle.
  assign issue_ready_o = any_empty || cdb_fire;
  assign alloc_idx     = any_empty ? free_idx : done_idx;
`else
  assign issue_ready_o = any_empty;
  assign alloc_idx     = free_idx;
`endif

  assign issue_fire    = issue_valid_i && issue_ready_o;
  assign iss_rs1_avail = issue_rs1_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs1_idx_i));
  assign iss_rs2_avail = issue_rs2_ready_i || (cdb_valid_i && (cdb_idx_i == issue_rs2_idx_i));
  assign iss_rs1_val   = issue_rs1_ready_i ? issue_rs1_value_i : cdb_data_i;
  assign iss_rs2_val   = issue_rs2_ready_i ? issue_rs2_value_i : cdb_data_i;

  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      state_d[i]  = state_q[i];
      issue_we[i] = 1'b0;
      cap1[i]     = 1'b0;
      cap2[i]     = 1'b0;
      res_we[i]   = 1'b0;
      case (state_q[i])
        WAIT_OP: begin
          cap1[i] = !rs1_rdy_q[i] && cdb_valid_i && (cdb_idx_i == rs1_idx_q[i]);
          cap2[i] = !rs2_rdy_q[i] && cdb_valid_i && (cdb_idx_i == rs2_idx_q[i]);
          if ((rs1_rdy_q[i] || cap1[i]) && (rs2_rdy_q[i] || cap2[i]))
            state_d[i] = READY;
        end
        READY:   if (eu_fire && (rdy_idx == IDX_W'(i))) state_d[i] = EXEC;
        EXEC: begin
          if (eu_valid_i && (eu_entry_idx_i == IDX_W'(i))) begin
            res_we[i]  = 1'b1;
            state_d[i] = DONE;
          end
        end
        DONE:    if (cdb_fire && (done_idx == IDX_W'(i))) state_d[i] = EMPTY;
        default: ;
      endcase
      if (issue_fire && (alloc_idx == IDX_W'(i))) begin
        issue_we[i] = 1'b1;
        state_d[i]  = (iss_rs1_avail && iss_rs2_avail) ? READY : WAIT_OP;
      end
      if (flush_i) begin
        state_d[i]  = EMPTY;
        issue_we[i] = 1'b0;
        cap1[i]     = 1'b0;
        cap2[i]     = 1'b0;
        res_we[i]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (rst_i) state_q[i] <= EMPTY;
      else       state_q[i] <= state_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (issue_we[i]) begin
        ctl_q[i]     <= issue_eu_ctl_i;
        rs1_rdy_q[i] <= iss_rs1_avail;
        rs2_rdy_q[i] <= iss_rs2_avail;
        rs1_idx_q[i] <= issue_rs1_idx_i;
        rs2_idx_q[i] <= issue_rs2_idx_i;
        rs1_val_q[i] <= iss_rs1_val;
        rs2_val_q[i] <= iss_rs2_val;
        dest_q[i]    <= issue_dest_idx_i;
      end else begin
        if (cap1[i]) begin
          rs1_rdy_q[i] <= 1'b1;
          rs1_val_q[i] <= cdb_data_i;
        end
        if (cap2[i]) begin
          rs2_rdy_q[i] <= 1'b1;
          rs2_val_q[i] <= cdb_data_i;
        end
      end
      if (res_we[i]) begin
        res_q[i] <= eu_result_i;
        exr_q[i] <= eu_except_raised_i;
        exc_q[i] <= eu_except_code_i;
      end
    end
  end

  always_comb begin
    eu_ctl_o            = '0;
    eu_rs1_o            = '0;
    eu_rs2_o            = '0;
    eu_entry_idx_o      = '0;
    cdb_idx_o           = '0;
    cdb_data_o          = '0;
    cdb_except_raised_o = 1'b0;
    cdb_except_code_o   = '0;
    if (!rst_i && any_ready) begin
      eu_ctl_o       = ctl_q[rdy_idx];
      eu_rs1_o       = rs1_val_q[rdy_idx];
      eu_rs2_o       = rs2_val_q[rdy_idx];
      eu_entry_idx_o = rdy_idx;
    end
    if (!rst_i && any_done) begin
      cdb_idx_o           = dest_q[done_idx];
      cdb_data_o          = res_q[done_idx];
      cdb_except_raised_o = exr_q[done_idx];
      cdb_except_code_o   = exc_q[done_idx];
    end
  end

endmodule

// File: tb/tb_fpu_rs.sv
// Directed bench for fpu_rs: per-cycle vector table plus hand sequences for full/flush cases.
module tb_fpu_rs;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        issue_valid_i, issue_ready_o;
  logic [3:0]  issue_eu_ctl_i;
  logic        issue_rs1_ready_i, issue_rs2_ready_i;
  logic [4:0]  issue_rs1_idx_i, issue_rs2_idx_i, issue_dest_idx_i;
  logic [31:0] issue_rs1_value_i, issue_rs2_value_i;
  logic        eu_valid_o, eu_ready_i;
  logic [3:0]  eu_ctl_o;
  logic [31:0] eu_rs1_o, eu_rs2_o;
  logic [1:0]  eu_entry_idx_o;
  logic        eu_valid_i, eu_ready_o;
  logic [1:0]  eu_entry_idx_i;
  logic [31:0] eu_result_i;
  logic        eu_except_raised_i;
  logic [1:0]  eu_except_code_i;
  logic        cdb_valid_i;
  logic [4:0]  cdb_idx_i;
  logic [31:0] cdb_data_i;
  logic        cdb_valid_o, cdb_ready_i;
  logic [4:0]  cdb_idx_o;
  logic [31:0] cdb_data_o;
  logic        cdb_except_raised_o;
  logic [1:0]  cdb_except_code_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fpu_rs #(.RS_DEPTH(4), .EU_CTL_LEN(4), .EXCEPT_LEN(2), .ROB_IDX_LEN(5), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_eu_ctl_i(issue_eu_ctl_i),
    .issue_rs1_ready_i(issue_rs1_ready_i), .issue_rs1_idx_i(issue_rs1_idx_i),
    .issue_rs1_value_i(issue_rs1_value_i),
    .issue_rs2_ready_i(issue_rs2_ready_i), .issue_rs2_idx_i(issue_rs2_idx_i),
    .issue_rs2_value_i(issue_rs2_value_i),
    .issue_dest_idx_i(issue_dest_idx_i),
    .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_ctl_o(eu_ctl_o),
    .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_entry_idx_o(eu_entry_idx_o),
    .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o), .eu_entry_idx_i(eu_entry_idx_i),
    .eu_result_i(eu_result_i), .eu_except_raised_i(eu_except_raised_i),
    .eu_except_code_i(eu_except_code_i),
    .cdb_valid_i(cdb_valid_i), .cdb_idx_i(cdb_idx_i), .cdb_data_i(cdb_data_i),
    .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i), .cdb_idx_o(cdb_idx_o),
    .cdb_data_o(cdb_data_o), .cdb_except_raised_o(cdb_except_raised_o),
    .cdb_except_code_o(cdb_except_code_o)
  );

  typedef struct packed {
    logic        iv;
    logic [3:0]  ctl;
    logic        r1r;
    logic [4:0]  r1i;
    logic [31:0] r1v;
    logic        r2r;
    logic [4:0]  r2i;
    logic [31:0] r2v;
    logic [4:0]  dest;
    logic        eur;
    logic        ev;
    logic [1:0]  eidx;
    logic [31:0] eres;
    logic        exr;
    logic [1:0]  exc;
    logic        cv;
    logic [4:0]  ci;
    logic [31:0] cd;
    logic        cr;
    logic        x_ir;
    logic        x_ev;
    logic [3:0]  x_ctl;
    logic [31:0] x_rs1;
    logic [31:0] x_rs2;
    logic [1:0]  x_eidx;
    logic        x_cv;
    logic [4:0]  x_ci;
    logic [31:0] x_cd;
    logic        x_exr;
    logic [1:0]  x_exc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    issue_valid_i      = v.iv;
    issue_eu_ctl_i     = v.ctl;
    issue_rs1_ready_i  = v.r1r;
    issue_rs1_idx_i    = v.r1i;
    issue_rs1_value_i  = v.r1v;
    issue_rs2_ready_i  = v.r2r;
    issue_rs2_idx_i    = v.r2i;
    issue_rs2_value_i  = v.r2v;
    issue_dest_idx_i   = v.dest;
    eu_ready_i         = v.eur;
    eu_valid_i         = v.ev;
    eu_entry_idx_i     = v.eidx;
    eu_result_i        = v.eres;
    eu_except_raised_i = v.exr;
    eu_except_code_i   = v.exc;
    cdb_valid_i        = v.cv;
    cdb_idx_i          = v.ci;
    cdb_data_i         = v.cd;
    cdb_ready_i        = v.cr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0]  = '{x_ir:1, default:'0};
    vecs[1]  = '{iv:1, ctl:3, r1r:1, r1v:10, r2r:1, r2v:2, dest:7, x_ir:1, default:'0};
    vecs[2]  = '{iv:1, ctl:1, r1i:4, r2r:1, r2v:3, dest:9, eur:1, x_ir:1,
                 x_ev:1, x_ctl:3, x_rs1:10, x_rs2:2, x_eidx:0, default:'0};
    vecs[3]  = '{eur:1, x_ir:1, default:'0};
    vecs[4]  = '{eur:1, x_ir:1, default:'0};
    vecs[5]  = '{cv:1, ci:4, cd:32'h55, ev:1, eidx:0, eres:5, x_ir:1, default:'0};
    vecs[6]  = '{x_ir:1, x_ev:1, x_ctl:1, x_rs1:32'h55, x_rs2:3, x_eidx:1,
                 x_cv:1, x_ci:7, x_cd:5, default:'0};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{cr:1, eur:1, x_ir:1, x_ev:1, x_ctl:1, x_rs1:32'h55, x_rs2:3, x_eidx:1,
                 x_cv:1, x_ci:7, x_cd:5, default:'0};
    vecs[10] = '{cr:1, ev:1, eidx:1, eres:32'hAB, exr:1, exc:2, x_ir:1, default:'0};
    vecs[11] = '{x_ir:1, x_cv:1, x_ci:9, x_cd:32'hAB, x_exr:1, x_exc:2, default:'0};
    vecs[12] = '{cr:1, x_ir:1, x_cv:1, x_ci:9, x_cd:32'hAB, x_exr:1, x_exc:2, default:'0};
    vecs[13] = '{ev:1, eidx:2, eres:32'hDEAD, x_ir:1, default:'0};
    vecs[14] = '{x_ir:1, default:'0};
    vecs[15] = '{iv:1, ctl:5, r1i:6, r2r:1, r2v:32'h77, dest:3, cv:1, ci:6, cd:32'h66,
                 x_ir:1, default:'0};
    vecs[16] = '{eur:1, x_ir:1, x_ev:1, x_ctl:5, x_rs1:32'h66, x_rs2:32'h77, x_eidx:0,
                 default:'0};
    vecs[17] = '{ev:1, eidx:0, eres:32'h11, x_ir:1, default:'0};
    vecs[18] = '{cr:1, x_ir:1, x_cv:1, x_ci:3, x_cd:32'h11, default:'0};
    vecs[19] = '{x_ir:1, default:'0};

    apply('{default:'0});
    flush_i = 1'b0;
    rst_i   = 1'b1;
    tick();
    chk("rst_eu_ready", 0, {31'b0, eu_ready_o}, 0);
    chk("rst_eu_rs1", 0, eu_rs1_o, 0);
    chk("rst_cdb_data", 0, cdb_data_o, 0);
    chk("rst_cdb_idx", 0, {27'b0, cdb_idx_o}, 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("post_rst_eu_ready", 0, {31'b0, eu_ready_o}, 1);

    for (int k = 0; k < NV; k++) begin
      apply(vecs[k]);
      #1;
      chk("issue_ready", k, {31'b0, issue_ready_o}, {31'b0, vecs[k].x_ir});
      chk("eu_valid", k, {31'b0, eu_valid_o}, {31'b0, vecs[k].x_ev});
      chk("cdb_valid", k, {31'b0, cdb_valid_o}, {31'b0, vecs[k].x_cv});
      if (vecs[k].x_ev) begin
        chk("eu_ctl", k, {28'b0, eu_ctl_o}, {28'b0, vecs[k].x_ctl});
        chk("eu_rs1", k, eu_rs1_o, vecs[k].x_rs1);
        chk("eu_rs2", k, eu_rs2_o, vecs[k].x_rs2);
        chk("eu_entry_idx", k, {30'b0, eu_entry_idx_o}, {30'b0, vecs[k].x_eidx});
      end
      if (vecs[k].x_cv) begin
        chk("cdb_idx", k, {27'b0, cdb_idx_o}, {27'b0, vecs[k].x_ci});
        chk("cdb_data", k, cdb_data_o, vecs[k].x_cd);
        chk("cdb_exr", k, {31'b0, cdb_except_raised_o}, {31'b0, vecs[k].x_exr});
        chk("cdb_exc", k, {30'b0, cdb_except_code_o}, {30'b0, vecs[k].x_exc});
      end
      tick();
    end

    // Fill all four entries while the EU is stalled.
    apply('{default:'0});
    for (int i = 0; i < 4; i++) begin
      issue_valid_i     = 1'b1;
      issue_eu_ctl_i    = 4'(i);
      issue_rs1_ready_i = 1'b1;
      issue_rs1_value_i = 32'h100 + 32'(i);
      issue_rs2_ready_i = 1'b1;
      issue_rs2_value_i = 32'h10 + 32'(i);
      issue_dest_idx_i  = 5'(10 + i);
      #1;
      chk("fill_issue_ready", 100 + i, {31'b0, issue_ready_o}, 1);
      tick();
    end
    issue_eu_ctl_i    = 4'd9;
    issue_rs1_value_i = 32'h200;
    issue_rs2_value_i = 32'h20;
    issue_dest_idx_i  = 5'd20;
    eu_ready_i        = 1'b1;
    #1;
    chk("full_issue_ready", 110, {31'b0, issue_ready_o}, 0);
    chk("full_eu_valid", 110, {31'b0, eu_valid_o}, 1);
    chk("full_eu_idx", 110, {30'b0, eu_entry_idx_o}, 0);
    tick();
    eu_ready_i     = 1'b0;
    eu_valid_i     = 1'b1;
    eu_entry_idx_i = 2'd0;
    eu_result_i    = 32'h300;
    #1;
    chk("full_issue_ready", 111, {31'b0, issue_ready_o}, 0);
    tick();
    eu_valid_i  = 1'b0;
    cdb_ready_i = 1'b1;
    #1;
    chk("free_cdb_valid", 112, {31'b0, cdb_valid_o}, 1);
    chk("free_cdb_idx", 112, {27'b0, cdb_idx_o}, 10);
    chk("free_cdb_data", 112, cdb_data_o, 32'h300);
`ifdef FPU_RS_EAGER_FREE_EN
    chk("free_issue_ready", 112, {31'b0, issue_ready_o}, 1);
    tick();
    cdb_ready_i   = 1'b0;
    issue_valid_i = 1'b0;
    #1;
`else
    chk("free_issue_ready", 112, {31'b0, issue_ready_o}, 0);
    tick();
    cdb_ready_i = 1'b0;
    #1;
    chk("late_issue_ready", 113, {31'b0, issue_ready_o}, 1);
    tick();
    issue_valid_i = 1'b0;
    #1;
`endif
    chk("refull_issue_ready", 114, {31'b0, issue_ready_o}, 0);
    eu_ready_i = 1'b1;
    #1;
    chk("reuse_eu_idx", 115, {30'b0, eu_entry_idx_o}, 0);
    chk("reuse_eu_rs1", 115, eu_rs1_o, 32'h200);
    chk("reuse_eu_ctl", 115, {28'b0, eu_ctl_o}, 9);
    tick();

    // Dispatch entry 1 while entry 0 returns its result, then flush.
    eu_valid_i         = 1'b1;
    eu_entry_idx_i     = 2'd0;
    eu_result_i        = 32'h400;
    eu_except_raised_i = 1'b1;
    eu_except_code_i   = 2'd1;
    #1;
    chk("dual_eu_idx", 120, {30'b0, eu_entry_idx_o}, 1);
    chk("dual_eu_rs1", 120, eu_rs1_o, 32'h101);
    tick();
    eu_ready_i = 1'b0;
    eu_valid_i = 1'b0;
    #1;
    chk("pre_flush_cdb_valid", 121, {31'b0, cdb_valid_o}, 1);
    chk("pre_flush_cdb_idx", 121, {27'b0, cdb_idx_o}, 20);
    chk("pre_flush_cdb_exr", 121, {31'b0, cdb_except_raised_o}, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_issue_ready", 122, {31'b0, issue_ready_o}, 1);
    chk("flush_eu_valid", 122, {31'b0, eu_valid_o}, 0);
    chk("flush_cdb_valid", 122, {31'b0, cdb_valid_o}, 0);
    eu_valid_i     = 1'b1;
    eu_entry_idx_i = 2'd1;
    eu_result_i    = 32'h500;
    tick();
    eu_valid_i = 1'b0;
    #1;
    chk("late_result_cdb_valid", 123, {31'b0, cdb_valid_o}, 0);
    chk("late_result_eu_valid", 123, {31'b0, eu_valid_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
